// File: rtl/set_pkg.sv
// set_pkg: shared mode encodings, field slices, grid limits and sequencer states for the SET engine
package set_pkg;
  localparam logic [1:0] SET_MODE_A     = 2'b00;
  localparam logic [1:0] SET_MODE_UNION = 2'b01;
  localparam logic [1:0] SET_MODE_DIFF  = 2'b10;
  localparam logic [1:0] SET_MODE_INTER = 2'b11;
  localparam int FIELD_W = 4;
  localparam int XA_LSB = 20;
  localparam int YA_LSB = 16;
  localparam int XB_LSB = 12;
  localparam int YB_LSB = 8;
  localparam int XC_LSB = 4;
  localparam int YC_LSB = 0;
  localparam int RA_LSB = 8;
  localparam int RB_LSB = 4;
  localparam int RC_LSB = 0;
  localparam int GRID_MIN = 1;
  localparam int GRID_MAX = 8;
  localparam int MAX_CAND = (GRID_MAX - GRID_MIN + 1) * (GRID_MAX - GRID_MIN + 1);
  localparam int WD_W = 15;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_WAIT_RDY, S_ISSUE, S_WAIT_VLD, S_CHECK, S_DONE
  } seq_state_t;
endpackage

// File: rtl/set_watchdog.sv
// set_watchdog: per-state wait counter that flags expiry after TIMEOUT enabled cycles
module set_watchdog
  import set_pkg::*;
#(
  parameter int TIMEOUT = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [WD_W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : en ? cnt + 1'b1 : cnt;
  assign expire = en && cnt == WD_W'(TIMEOUT - 1);
endmodule

// File: rtl/set_pattern_sequencer.sv
// set_pattern_sequencer: walks the pattern ROM, issues one SET job per pattern and grades the results
module set_pattern_sequencer
  import set_pkg::*;
#(
  parameter int NUM_PAT = 64,
  parameter int ADDR_W  = 6,
  parameter int MAX_ERR = 10,
  parameter int TIMEOUT = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [23:0]       rom_central,
  input  logic [11:0]       rom_radius,
  input  logic [7:0]        rom_expected,
  output logic              set_en,
  output logic [23:0]       set_central,
  output logic [11:0]       set_radius,
  output logic [1:0]        set_mode,
  input  logic              set_busy,
  input  logic              set_valid,
  input  logic [7:0]        set_candidate,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [6:0]        err_cnt,
  output logic [ADDR_W-1:0] first_fail
);
  seq_state_t state, state_n;
  logic [ADDR_W-1:0] idx;
  logic [7:0] exp_r, cand_r;
  logic [6:0] err_n;
  logic mis, last, wd_exp, wd_clr, wd_en;
  assign wd_clr = state_n != state;
  assign wd_en = state == S_WAIT_RDY || state == S_WAIT_VLD;
  set_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk), .rst(rst), .clr(wd_clr), .en(wd_en), .expire(wd_exp)
  );
  // equality is tested positively so an unknown candidate falls through to a mismatch
  always_comb begin
    mis = 1'b1;
    if (cand_r == exp_r) mis = 1'b0;
    err_n = (mis && err_cnt != 7'(MAX_ERR)) ? err_cnt + 7'd1 : err_cnt;
    last = err_n == 7'(MAX_ERR) || idx == ADDR_W'(NUM_PAT - 1);
    state_n = state;
    case (state)
      S_IDLE, S_DONE: state_n = start ? S_FETCH : state;
      S_FETCH:        state_n = S_LOAD;
      S_LOAD:         state_n = S_WAIT_RDY;
      S_WAIT_RDY:     state_n = !set_busy ? S_ISSUE : wd_exp ? S_DONE : S_WAIT_RDY;
      S_ISSUE:        state_n = S_WAIT_VLD;
      S_WAIT_VLD:     state_n = set_valid ? S_CHECK : wd_exp ? S_DONE : S_WAIT_VLD;
      S_CHECK:        state_n = last ? S_DONE : S_FETCH;
      default:        state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    state <= rst ? S_IDLE : state_n;
  always_ff @(posedge clk)
    if (rst) begin
      idx <= '0;
      set_mode <= '0;
      set_central <= '0;
      set_radius <= '0;
      exp_r <= '0;
      cand_r <= '0;
      err_cnt <= '0;
      first_fail <= '0;
      timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          set_mode <= mode;
          idx <= '0;
          err_cnt <= '0;
          first_fail <= '0;
          timeout <= 1'b0;
        end
        S_LOAD: begin
          set_central <= rom_central;
          set_radius <= rom_radius;
          exp_r <= rom_expected;
        end
        S_WAIT_RDY: if (set_busy && wd_exp) timeout <= 1'b1;
        S_WAIT_VLD: if (set_valid) cand_r <= set_candidate; else if (wd_exp) timeout <= 1'b1;
        S_CHECK: begin
          err_cnt <= err_n;
          if (mis && err_cnt == '0) first_fail <= idx;
          if (!last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  assign rom_addr = idx;
  assign set_en = state == S_ISSUE;
  assign done = state == S_DONE;
  assign pass = done && err_cnt == '0 && !timeout;
endmodule

// File: tb/tb_set_pattern_sequencer.sv
// tb_set_pattern_sequencer: random ROM runs against a behavioural SET model with a job scoreboard
module tb_set_pattern_sequencer;
  localparam int NUM_PAT = 64;
  localparam int ADDR_W = 6;
  localparam int MAX_ERR = 10;
  localparam int TIMEOUT = 20000;
  typedef struct {int idx; logic [23:0] c; logic [11:0] r;} job_t;
  logic clk = 0, rst = 1, start = 0;
  logic [1:0] mode = 0;
  logic [ADDR_W-1:0] rom_addr, first_fail;
  logic [23:0] rom_central, set_central;
  logic [11:0] rom_radius, set_radius;
  logic [7:0] rom_expected, set_candidate = 0;
  logic set_en, set_busy = 0, set_valid = 0, done, pass, timeout;
  logic [1:0] set_mode;
  logic [6:0] err_cnt;
  logic [23:0] rc[NUM_PAT];
  logic [11:0] rr[NUM_PAT];
  logic [7:0] re[NUM_PAT];
  logic [63:0] fault = 0;
  logic [1:0] run_mode = 0;
  bit never_valid = 0, ext_busy = 0;
  int busy_len = 66, clr_req = 0, late_req = 0;
  int checks = 0, errors = 0, en_cnt = 0, stab_bad = 0;
  job_t sb[$];
  set_pattern_sequencer #(.NUM_PAT(NUM_PAT), .ADDR_W(ADDR_W), .MAX_ERR(MAX_ERR), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .rom_addr(rom_addr),
    .rom_central(rom_central), .rom_radius(rom_radius), .rom_expected(rom_expected),
    .set_en(set_en), .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
    .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate),
    .done(done), .pass(pass), .timeout(timeout), .err_cnt(err_cnt), .first_fail(first_fail)
  );
  initial forever #5 clk = ~clk;
  always @(posedge clk) begin
    rom_central <= rc[rom_addr];
    rom_radius <= rr[rom_addr];
    rom_expected <= re[rom_addr];
  end
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic bit in_circ(input int x, input int y, input logic [3:0] cx, input logic [3:0] cy, input logic [3:0] r);
    return (x - int'(cx)) * (x - int'(cx)) + (y - int'(cy)) * (y - int'(cy)) <= int'(r) * int'(r);
  endfunction
  // candidate count on the 8x8 grid for the selected set combination
  function automatic int ref_count(input logic [1:0] m, input logic [23:0] c, input logic [11:0] r);
    int n = 0;
    for (int x = 1; x <= 8; x++)
      for (int y = 1; y <= 8; y++) begin
        bit a, b, k, hit;
        a = in_circ(x, y, c[23:20], c[19:16], r[11:8]);
        b = in_circ(x, y, c[15:12], c[11:8], r[7:4]);
        k = in_circ(x, y, c[7:4], c[3:0], r[3:0]);
        case (m)
          2'd0: hit = a;
          2'd1: hit = a | b;
          2'd2: hit = a ^ b;
          default: hit = a & b & k;
        endcase
        n += int'(hit);
      end
    return n;
  endfunction
  function automatic void predict(input logic [63:0] f, output int e, output int ff, output int n);
    e = 0; ff = 0; n = NUM_PAT;
    for (int i = 0; i < NUM_PAT; i++) begin
      if (f[i]) begin
        if (e == 0) ff = i;
        e++;
      end
      if (e == MAX_ERR) begin
        n = i + 1;
        break;
      end
    end
  endfunction
  // SET model: drives after each rising edge, busy while a job is in flight
  initial begin
    bit pend;
    int cnt, clr_seen, late_seen;
    logic [23:0] jc;
    logic [7:0] resp;
    pend = 0; cnt = 0; clr_seen = 0; late_seen = 0; jc = 0; resp = 0;
    forever begin
      @(posedge clk);
      #1;
      set_valid = 0;
      if (clr_req != clr_seen) begin clr_seen = clr_req; pend = 0; end
      if (late_req != late_seen) begin late_seen = late_req; set_valid = 1; set_candidate = 8'hff; end
      if (pend) begin
        if (set_central != jc) stab_bad++;
        if (cnt > 0) cnt--;
        else if (!never_valid) begin set_valid = 1; set_candidate = resp; pend = 0; end
      end
      if (set_en) begin
        pend = 1; cnt = busy_len; jc = set_central;
        resp = 8'(ref_count(set_mode, set_central, set_radius) + int'(fault[rom_addr]));
      end
      set_busy = ext_busy || pend;
    end
  end
  // monitor: every issued job is popped from the scoreboard and compared
  initial begin
    job_t j;
    bit prev_busy;
    prev_busy = 0;
    forever begin
      @(negedge clk);
      if (set_en) begin
        en_cnt++;
        chk("busy_at_issue", longint'(prev_busy), 0);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_set_en: got issue at idx %0d expected none", rom_addr);
        end else begin
          j = sb.pop_front();
          chk("job_idx", rom_addr, j.idx);
          chk("job_central", set_central, j.c);
          chk("job_radius", set_radius, j.r);
          chk("job_mode", set_mode, run_mode);
        end
      end
      prev_busy = set_busy;
    end
  end
  task automatic launch(input logic [63:0] f, input int bl, input bit nv, input int n_issue);
    fault = f; busy_len = bl; never_valid = nv;
    run_mode = 2'($urandom_range(0, 3));
    sb.delete();
    for (int i = 0; i < NUM_PAT; i++) begin
      rc[i] = 24'($urandom);
      rr[i] = 12'($urandom);
      re[i] = 8'(ref_count(run_mode, rc[i], rr[i]));
      if (i < n_issue) sb.push_back('{i, rc[i], rr[i]});
    end
    en_cnt = 0; stab_bad = 0;
    @(negedge clk);
    mode = run_mode; start = 1;
    @(negedge clk);
    start = 0; mode = 2'($urandom);
  endtask
  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin @(negedge clk); k++; end
    chk("done_reached", done, 1);
  endtask
  task automatic final_checks(input logic [63:0] f, input bit to);
    int e, ff, n;
    predict(f, e, ff, n);
    if (to) begin e = 0; ff = 0; n = 1; end
    chk("err_cnt", err_cnt, e);
    chk("first_fail", first_fail, ff);
    chk("pass", pass, longint'(e == 0 && !to));
    chk("timeout", timeout, longint'(to));
    chk("issued", en_cnt, n);
    chk("sb_empty", sb.size(), 0);
    chk("central_stable", stab_bad, 0);
  endtask
  initial begin
    #950_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    int k;
    logic [63:0] f2;
    f2 = 0; f2[5] = 1; f2[9] = 1;
    repeat (3) @(negedge clk);
    chk("rst_set_en", set_en, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_first_fail", first_fail, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_set_central", set_central, 0);
    rst = 0;
    launch('0, 66, 0, NUM_PAT); wait_done(30000); final_checks('0, 0);
    launch(f2, 66, 0, NUM_PAT); wait_done(30000); final_checks(f2, 0);
    launch('1, 66, 0, MAX_ERR); wait_done(30000); final_checks('1, 0);
    chk("abort_done", done, 1);
    ext_busy = 1;
    launch('0, 66, 0, NUM_PAT);
    repeat (500) @(negedge clk);
    chk("no_issue_while_busy", en_cnt, 0);
    ext_busy = 0;
    k = 0;
    do begin @(negedge clk); k++; end while (set_busy && k < 4);
    @(negedge clk);
    chk("en_after_busy_fall", set_en, 1);
    wait_done(30000); final_checks('0, 0);
    launch('0, 66, 0, 4);
    k = 0;
    while (en_cnt < 4 && k < 2000) begin @(negedge clk); k++; end
    repeat (10) @(negedge clk);
    chk("rst_point_idx", rom_addr, 3);
    rst = 1; clr_req++;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("midrst_set_en", set_en, 0);
    chk("midrst_rom_addr", rom_addr, 0);
    chk("midrst_done", done, 0);
    late_req++;
    repeat (5) @(negedge clk);
    chk("late_valid_err", err_cnt, 0);
    chk("late_valid_done", done, 0);
    chk("late_valid_issue", en_cnt, 4);
    chk("midrst_sb_empty", sb.size(), 0);
    launch('0, 66, 0, NUM_PAT); wait_done(30000); final_checks('0, 0);
    launch('0, 66, 1, 1); wait_done(TIMEOUT + 5000); final_checks('0, 1);
    clr_req++;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
